lcd_capture: RTL and testbench
==============================

LCD_CAPTURE -- requirements
Module: lcd_capture

Interface
REQ-001 clock  input  1  system clock, 50 MHz; all logic on its rising edge.
REQ-002 reset_n  input  1  synchronous, active-low reset, sampled on the clock rising edge.
REQ-003 tick  input  1  pixel-sample enable, one clock wide; the LCD signals are valid only in cycles where tick=1.
REQ-004 hs_n  input  1  horizontal sync, active low; monitored only.
REQ-005 vs_n  input  1  vertical sync, active low; a sampled high-to-low edge starts a frame.
REQ-006 de  input  1  data enable; high marks an active pixel.
REQ-007 red, green, blue  input  8 each  pixel colour components.
REQ-008 pixel_valid  output  1  one-clock strobe; a captured pixel is present.
REQ-009 pixel_x, pixel_y  output  10 each  coordinates of the captured pixel.
REQ-010 pixel_rgb  output  24  captured pixel, {red, green, blue}.
REQ-011 frame_start  output  1  one-clock strobe on a detected vs_n falling edge.
REQ-012 frame_done  output  1  one-clock strobe; the previous frame's measurements are updated.
REQ-013 width, height  output  10 each  active pixels per line and active lines of the last completed frame.
REQ-014 locked  output  1  two consecutive error-free frames had identical width and height.
REQ-015 error  output  1  sticky flag, cleared only by reset.
REQ-016 checksum  output  32  frame checksum (see Configuration).

Function
REQ-017 SHALL sample hs_n, vs_n, de and rgb only in cycles with tick=1, and keep the previous sampled vs_n and de for edge detection.
REQ-018 SHALL implement states WAIT_VSYNC, WAIT_ACTIVE and ACTIVE.
  - WAIT_VSYNC -> WAIT_ACTIVE on a vs_n falling edge.
  - WAIT_ACTIVE -> ACTIVE when de=1.
  - ACTIVE -> WAIT_ACTIVE when de=0.
  - From any state, a vs_n falling edge restarts the frame.
REQ-019 SHALL ignore de=1 while in WAIT_VSYNC: no pixel_valid and no error.
REQ-020 SHALL, for each sampled pixel with de=1 outside WAIT_VSYNC, assert pixel_valid exactly one clock after the tick cycle, with that pixel's x, y and rgb.
REQ-021 SHALL set x=0 on the first de=1 sample of a line and add 1 per subsequent de=1 sample.
REQ-022 SHALL increment the line counter y on each de falling edge (sampled).
REQ-023 SHALL reset x and y to 0 on a vs_n falling edge.
REQ-024 SHALL record the first line's length as the frame reference width.
REQ-025 SHALL set error when a later line's length differs from the reference width.
REQ-026 SHALL set error and suppress pixel_valid for pixels with x>1023, saturating x at 1023.
REQ-027 SHALL set error and saturate y at 1023 if more than 1024 lines occur in a frame.
REQ-028 SHALL, on a vs_n falling edge that follows at least one active line, update width/height and pulse frame_done one clock after the tick.
REQ-029 SHALL assert frame_start in that same cycle on every vs_n falling edge.
REQ-030 SHALL, when de falls and vs_n falls in the same tick, count the line before closing the frame.
REQ-031 SHALL set locked on the second consecutive matching error-free frame and clear it on a mismatching or errored frame; it stays 0 after reset until that occurs.
REQ-032 SHALL leave all outputs and counters unchanged in cycles with tick=0, except that the one-clock strobes return to 0.

Reset
REQ-033 SHALL, while reset_n=0 at a clock edge:
  - enter WAIT_VSYNC;
  - drive pixel_valid, frame_start, frame_done, locked, error = 0;
  - clear pixel_x, pixel_y, pixel_rgb, width, height and checksum to 0, and clear the sampled-history registers so vs_n and de read as 1 and 0 respectively.
REQ-034 SHALL discard a frame that is in progress when reset occurs; capture resumes only after the next vs_n falling edge.

Configuration
REQ-035 SHALL, with LCD_CAPTURE_CHECKSUM_EN defined:
  - add {8'h00, rgb} of each pixel that produces pixel_valid to an accumulator, modulo 2^32;
  - copy the accumulator to checksum with frame_done, then clear it;
  - clear it on every vs_n falling edge.
REQ-036 SHALL, without LCD_CAPTURE_CHECKSUM_EN, still provide the checksum port, tie it to constant 0, and implement no accumulator.

Verification
REQ-037 4x3 frame, tick every 2nd clock, pixel value = y*4+x -> 12 pixel_valid strobes, last at x=3 y=2; at the next vs_n edge width=4, height=3, frame_done=1, error=0.
REQ-038 Same 4x3 frame sent twice -> locked=0 after frame 1 and 1 after frame 2; a third frame of 5x3 -> locked=0.
REQ-039 Line lengths 4,4,3 -> error=1, which stays 1 over subsequent good frames until reset_n=0.
REQ-040 de high before any vs_n edge, then a 2x2 frame -> no pixel_valid before the vs_n edge, 4 pixels after, error=0.
REQ-041 reset_n=0 for 1 clock in the middle of line 1 -> all outputs 0, no pixel_valid until the next vs_n edge, the next full frame measured correctly.
REQ-042 With LCD_CAPTURE_CHECKSUM_EN, a 2x1 frame with pixels 24'hFFFFFF and 24'h000001 -> checksum=32'h01000000 at frame_done; without the macro -> checksum=0.

Source files
------------

// File: rtl/lcd_capture.sv
`default_nettype none
// ============================================================================
// Module   : lcd_capture
// Purpose  : Captures pixels from a tick-qualified parallel RGB LCD stream and
//            measures each frame's geometry. Define LCD_CAPTURE_CHECKSUM_EN to
//            enable the per-frame pixel checksum.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_capture (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        hs_n,
    input  logic        vs_n,
    input  logic        de,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic        pixel_valid,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic [23:0] pixel_rgb,
    output logic        frame_start,
    output logic        frame_done,
    output logic [9:0]  width,
    output logic [9:0]  height,
    output logic        locked,
    output logic        error,
    output logic [31:0] checksum
);

    typedef enum logic [1:0] {
        WAIT_VSYNC  = 2'd0,
        WAIT_ACTIVE = 2'd1,
        ACTIVE      = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_vs_prev, r_de_prev;
    logic [10:0] r_cnt, r_lines, r_ref;
    logic        r_frame_err, r_prev_ok;
    logic        r_pixel_valid, r_frame_start, r_frame_done, r_locked, r_error;
    logic [9:0]  r_pixel_x, r_pixel_y, r_width, r_height;
    logic [23:0] r_pixel_rgb;

    logic        w_vs_fall, w_line_end, w_len_err, w_frame_bad, w_frame_close;
    logic        w_pix, w_pix_ok, w_unused;
    logic [10:0] w_lines_after, w_ref_after, w_x_cur;
    logic [9:0]  w_w_new, w_h_new, w_y_cur;

    // Counters are one bit wider than the outputs so 1024 marks overflow.
    assign w_vs_fall     = tick & r_vs_prev & ~vs_n;
    assign w_line_end    = tick & (r_state == ACTIVE) & r_de_prev & ~de;
    assign w_lines_after = (w_line_end && !r_lines[10]) ? r_lines + 11'd1 : r_lines;
    assign w_ref_after   = (w_line_end && r_lines == 11'd0) ? r_cnt : r_ref;
    assign w_len_err     = w_line_end && (r_lines != 11'd0) && (r_cnt != r_ref);
    assign w_frame_bad   = r_frame_err | w_len_err;
    assign w_frame_close = w_vs_fall && (w_lines_after != 11'd0);
    assign w_w_new       = w_ref_after[10] ? 10'd1023 : w_ref_after[9:0];
    assign w_h_new       = w_lines_after[10] ? 10'd1023 : w_lines_after[9:0];
    assign w_y_cur       = r_lines[10] ? 10'd1023 : r_lines[9:0];
    assign w_x_cur       = (r_state == ACTIVE) ? r_cnt : 11'd0;
    assign w_pix         = tick & de & ~w_vs_fall & (r_state != WAIT_VSYNC);
    assign w_pix_ok      = w_pix & ~w_x_cur[10];
    assign w_unused      = hs_n;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= WAIT_VSYNC;
            r_vs_prev     <= 1'b1;
            r_de_prev     <= 1'b0;
            r_cnt         <= 11'd0;
            r_lines       <= 11'd0;
            r_ref         <= 11'd0;
            r_frame_err   <= 1'b0;
            r_prev_ok     <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_locked      <= 1'b0;
            r_error       <= 1'b0;
            r_pixel_x     <= 10'd0;
            r_pixel_y     <= 10'd0;
            r_pixel_rgb   <= 24'd0;
            r_width       <= 10'd0;
            r_height      <= 10'd0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            if (tick) begin
                r_vs_prev <= vs_n;
                r_de_prev <= de;
                if (w_vs_fall) begin
                    // A line ending in this same tick is already folded into w_*_after.
                    r_frame_start <= 1'b1;
                    if (w_frame_close) begin
                        r_frame_done <= 1'b1;
                        r_width      <= w_w_new;
                        r_height     <= w_h_new;
                        r_locked     <= !w_frame_bad && r_prev_ok &&
                                        (w_w_new == r_width) && (w_h_new == r_height);
                        r_prev_ok    <= !w_frame_bad;
                    end
                    if (w_len_err)
                        r_error <= 1'b1;
                    r_state     <= WAIT_ACTIVE;
                    r_cnt       <= 11'd0;
                    r_lines     <= 11'd0;
                    r_ref       <= 11'd0;
                    r_frame_err <= 1'b0;
                end else if (w_line_end) begin
                    r_state <= WAIT_ACTIVE;
                    r_lines <= w_lines_after;
                    r_ref   <= w_ref_after;
                    if (w_len_err) begin
                        r_error     <= 1'b1;
                        r_frame_err <= 1'b1;
                    end
                end else if (w_pix) begin
                    r_state <= ACTIVE;
                    if (w_x_cur[10]) begin
                        r_error     <= 1'b1;
                        r_frame_err <= 1'b1;
                        r_pixel_x   <= 10'd1023;
                    end else begin
                        r_pixel_valid <= 1'b1;
                        r_pixel_x     <= w_x_cur[9:0];
                        r_pixel_y     <= w_y_cur;
                        r_pixel_rgb   <= {red, green, blue};
                        r_cnt         <= w_x_cur + 11'd1;
                    end
                    // Starting a 1025th line.
                    if (r_state == WAIT_ACTIVE && r_lines[10]) begin
                        r_error     <= 1'b1;
                        r_frame_err <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef LCD_CAPTURE_CHECKSUM_EN
    logic [31:0] r_acc, r_checksum;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_acc      <= 32'd0;
            r_checksum <= 32'd0;
        end else if (tick) begin
            if (w_vs_fall) begin
                if (w_frame_close)
                    r_checksum <= r_acc;
                r_acc <= 32'd0;
            end else if (w_pix_ok) begin
                r_acc <= r_acc + {8'h00, red, green, blue};
            end
        end
    end

    assign checksum = r_checksum;
`else
    logic w_unused_pix;
    assign w_unused_pix = w_pix_ok;
    assign checksum     = 32'd0;
`endif

    assign pixel_valid = r_pixel_valid;
    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign pixel_rgb   = r_pixel_rgb;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign width       = r_width;
    assign height      = r_height;
    assign locked      = r_locked;
    assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_lcd_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_capture
// Purpose  : Directed and randomized frames against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_capture;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic        hs_n = 1'b1;
    logic        vs_n = 1'b1;
    logic        de = 1'b0;
    logic [7:0]  red = 8'd0, green = 8'd0, blue = 8'd0;
    logic        pixel_valid, frame_start, frame_done, locked, error;
    logic [9:0]  pixel_x, pixel_y, width, height;
    logic [23:0] pixel_rgb;
    logic [31:0] checksum;

    lcd_capture dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .tick        (tick),
        .hs_n        (hs_n),
        .vs_n        (vs_n),
        .de          (de),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .pixel_valid (pixel_valid),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_rgb   (pixel_rgb),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .width       (width),
        .height      (height),
        .locked      (locked),
        .error       (error),
        .checksum    (checksum)
    );

    always #5 clock = ~clock;

    typedef logic [43:0] pix_t;   // {x, y, rgb}

    int          checks = 0;
    int          failures = 0;
    pix_t        exp_q[$];
    pix_t        obs_q[$];
    int          fd_seen = 0, fs_seen = 0, fd_exp = 0, fs_exp = 0;
    int          fr[$];
    logic [23:0] fixed_rgb[$];
    int          cur_lens[$];
    logic [31:0] cur_sum = 32'd0;
    bit          capturing = 1'b0;
    bit          m_error = 1'b0, m_prev_ok = 1'b0, m_locked = 1'b0;
    int          m_prev_w = 0, m_prev_h = 0, m_w = 0, m_h = 0;
    logic [31:0] m_cks = 32'd0;

    always @(negedge clock) begin
        if (pixel_valid) obs_q.push_back({pixel_x, pixel_y, pixel_rgb});
        if (frame_done)  fd_seen++;
        if (frame_start) fs_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input bit ok,
                       input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sampled LCD cycle; inputs are scrambled while tick is low.
    task automatic do_tick(input logic v, input logic d, input logic [23:0] rgb);
        @(negedge clock);
        vs_n = v; de = d; hs_n = d | 1'($urandom_range(0, 1));
        {red, green, blue} = rgb; tick = 1'b1;
        @(negedge clock);
        tick = 1'b0; vs_n = 1'($urandom_range(0, 1)); de = 1'($urandom_range(0, 1));
        {red, green, blue} = 24'($urandom);
        repeat ($urandom_range(0, 1)) @(negedge clock);
    endtask

    task automatic compare_pixels();
        chk("pix_count", obs_q.size() === exp_q.size(), obs_q.size(), exp_q.size());
        if (obs_q.size() == exp_q.size())
            foreach (exp_q[i]) chk("pixel", obs_q[i] === exp_q[i], obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_outputs();
        #1;
        chk("frame_start_cnt", fs_seen === fs_exp, fs_seen, fs_exp);
        chk("frame_done_cnt", fd_seen === fd_exp, fd_seen, fd_exp);
        chk("width", width === 10'(m_w), width, m_w);
        chk("height", height === 10'(m_h), height, m_h);
        chk("error", error === m_error, error, m_error);
        chk("locked", locked === m_locked, locked, m_locked);
        chk("checksum", checksum === m_cks, checksum, m_cks);
        compare_pixels();
    endtask

    // Frame-level expectations derived from the list of line lengths.
    task automatic close_model();
        int  w, h;
        bit  bad;
        w   = (cur_lens[0] > 1023) ? 1023 : cur_lens[0];
        h   = (cur_lens.size() > 1023) ? 1023 : cur_lens.size();
        bad = (cur_lens.size() > 1024);
        foreach (cur_lens[i])
            if (cur_lens[i] != cur_lens[0] || cur_lens[i] > 1024) bad = 1'b1;
        m_locked  = !bad && m_prev_ok && (w == m_prev_w) && (h == m_prev_h);
        m_prev_ok = !bad;
        m_prev_w  = w;
        m_prev_h  = h;
        m_w       = w;
        m_h       = h;
        m_error   = m_error | bad;
`ifdef LCD_CAPTURE_CHECKSUM_EN
        m_cks     = cur_sum;
`else
        m_cks     = 32'd0;
`endif
        fd_exp++;
    endtask

    task automatic frame_edge(input bit open_line);
        if (!open_line) do_tick(1'b1, 1'b0, 24'd0);
        do_tick(1'b0, 1'b0, 24'd0);
        fs_exp++;
        if (capturing && cur_lens.size() > 0) close_model();
        cur_lens.delete();
        cur_sum   = 32'd0;
        capturing = 1'b1;
        check_outputs();
        do_tick(1'b0, 1'b0, 24'd0);
        do_tick(1'b1, 1'b0, 24'd0);
    endtask

    task automatic send_body(input bit open_end);
        logic [23:0] rgb;
        foreach (fr[l]) begin
            do_tick(1'b1, 1'b0, 24'd0);
            for (int x = 0; x < fr[l]; x++) begin
                rgb = (fixed_rgb.size() > 0) ? fixed_rgb.pop_front() : 24'($urandom);
                do_tick(1'b1, 1'b1, rgb);
                if (capturing && x < 1024) begin
                    exp_q.push_back({10'(x), 10'((l > 1023) ? 1023 : l), rgb});
                    cur_sum = cur_sum + {8'h00, rgb};
                end
            end
            cur_lens.push_back(fr[l]);
        end
        if (!open_end) do_tick(1'b1, 1'b0, 24'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, pixel_valid === 1'b0, pixel_valid, 0);
        chk({tag, "_fstart"}, frame_start === 1'b0, frame_start, 0);
        chk({tag, "_fdone"}, frame_done === 1'b0, frame_done, 0);
        chk({tag, "_locked"}, locked === 1'b0, locked, 0);
        chk({tag, "_error"}, error === 1'b0, error, 0);
        chk({tag, "_x"}, pixel_x === 10'd0, pixel_x, 0);
        chk({tag, "_y"}, pixel_y === 10'd0, pixel_y, 0);
        chk({tag, "_rgb"}, pixel_rgb === 24'd0, pixel_rgb, 0);
        chk({tag, "_width"}, width === 10'd0, width, 0);
        chk({tag, "_height"}, height === 10'd0, height, 0);
        chk({tag, "_checksum"}, checksum === 32'd0, checksum, 0);
    endtask

    task automatic set_frame(input int w, input int h);
        fr.delete();
        repeat (h) fr.push_back(w);
    endtask

    initial begin
        int w, h;
        bit open;
        repeat (3) @(negedge clock);
        check_zero("reset");
        reset_n = 1'b1;

        // de before any vsync edge must be ignored
        repeat (4) do_tick(1'b1, 1'b1, 24'($urandom));
        do_tick(1'b1, 1'b0, 24'd0);
        #1;
        chk("pre_vsync_pixels", obs_q.size() === 0, obs_q.size(), 0);
        frame_edge(1'b0);
        set_frame(2, 2); send_body(1'b0); frame_edge(1'b0);

        // 4x3 with pixel value y*4+x, sent twice, then 5x3
        for (int i = 0; i < 12; i++) fixed_rgb.push_back(24'(i));
        set_frame(4, 3); send_body(1'b0); frame_edge(1'b0);
        chk("req037_width", width === 10'd4, width, 4);
        chk("req037_height", height === 10'd3, height, 3);
        set_frame(4, 3); send_body(1'b0); frame_edge(1'b0);
        chk("req038_locked", locked === 1'b1, locked, 1);
        set_frame(5, 3); send_body(1'b0); frame_edge(1'b0);

        // mismatched line lengths, then good frames keep error sticky
        fr = {4, 4, 3}; send_body(1'b0); frame_edge(1'b0);
        chk("req039_error", error === 1'b1, error, 1);
        set_frame(3, 2); send_body(1'b0); frame_edge(1'b0);
        set_frame(3, 2); send_body(1'b0); frame_edge(1'b0);

        // reset in the middle of line 1
        set_frame(4, 1); send_body(1'b1);
        @(negedge clock); tick = 1'b0; reset_n = 1'b0;
        @(negedge clock); reset_n = 1'b1;
        check_zero("midreset");
        compare_pixels();
        m_error = 1'b0; m_prev_ok = 1'b0; m_locked = 1'b0;
        m_w = 0; m_h = 0; m_cks = 32'd0; capturing = 1'b0;
        cur_lens.delete(); cur_sum = 32'd0;
        repeat (3) do_tick(1'b1, 1'b1, 24'($urandom));
        do_tick(1'b1, 1'b0, 24'd0);
        #1;
        chk("post_reset_pixels", obs_q.size() === 0, obs_q.size(), 0);
        frame_edge(1'b0);
        set_frame(2, 2); send_body(1'b0); frame_edge(1'b0);

        // checksum carry case
        fixed_rgb = {24'hFFFFFF, 24'h000001};
        set_frame(2, 1); send_body(1'b0); frame_edge(1'b0);
`ifdef LCD_CAPTURE_CHECKSUM_EN
        chk("req042_checksum", checksum === 32'h01000000, checksum, 32'h01000000);
`else
        chk("req042_checksum", checksum === 32'h0, checksum, 32'h0);
`endif

        // de and vs_n falling in the same tick
        set_frame(3, 2); send_body(1'b1); frame_edge(1'b1);

        // randomized frames, often repeating geometry
        w = 3; h = 2;
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 1) == 0) begin
                w = $urandom_range(1, 8);
                h = $urandom_range(1, 4);
            end
            set_frame(w, h);
            if ($urandom_range(0, 4) == 0) fr[$urandom_range(0, h - 1)] = w + 1;
            open = 1'($urandom_range(0, 1));
            send_body(open); frame_edge(open);
        end

        // x and y overflow
        set_frame(1030, 1); send_body(1'b0); frame_edge(1'b0);
        set_frame(1, 1026); send_body(1'b0); frame_edge(1'b0);
        set_frame(2, 1); send_body(1'b0); frame_edge(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
